pc_fetch_ctrl: RTL and testbench

Parametrised program-counter and fetch-address controller; successor to the single-register PC.
- Holds the architectural fetch PC and issues it to instruction memory with a valid/ready handshake.
- Selects the next PC from: sequential, branch, jump, return, trap.
- Contains an optional return-address stack (RAS) and a halt/boot state machine.
- Sits between the decode/execute redirect logic and the instruction memory port.

---
 rtl/pc_pkg.sv | 28 ++
 rtl/pc_ras.sv | 59 +++++
 rtl/pc_fetch_ctrl.sv | 158 +++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the program-counter / fetch controller.
//   fetch_state_t : fetch state machine encoding (BOOT, RUN, HALT)
//   next_sel_t    : next-PC source, listed in priority order
//   INSTR_BYTES   : sequential PC increment
//   DEF_*         : default parameter values for pc_fetch_ctrl
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } fetch_state_t;

    typedef enum logic [2:0] {
        SEL_TRAP,
        SEL_RET,
        SEL_JMP,
        SEL_BR,
        SEL_SEQ,
        SEL_HOLD
    } next_sel_t;

    localparam int          INSTR_BYTES      = 4;
    localparam int          DEF_XLEN         = 32;
    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0080;

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack.
//   clk, reset  : clock, asynchronous active-high reset (clears the entry count)
//   push        : write push_data as the new top
//   pop         : drop the top entry (ignored while empty)
//   push_data   : address pushed
//   top         : current top entry (undefined while empty)
//   empty, full : occupancy flags
// A push while full overwrites the oldest entry. Push together with pop
// replaces the top entry in place and leaves the count unchanged.
module pc_ras #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            empty,
    output logic            full
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   top_idx;
    logic [CW-1:0]   count;
    logic            do_pop;

    // ptr is the next free slot; wrapping it makes a full push land on the oldest entry
    assign top_idx = ptr - PW'(1);
    assign top     = mem[top_idx];
    assign empty   = (count == '0);
    assign full    = (count == CW'(RAS_DEPTH));
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr   <= '0;
            count <= '0;
        end else if (push && do_pop) begin
            ptr   <= ptr;
        end else if (push) begin
            ptr <= ptr + PW'(1);
            if (!full) count <= count + CW'(1);
        end else if (do_pop) begin
            ptr   <= ptr - PW'(1);
            count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[do_pop ? top_idx : ptr] <= push_data;
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: architectural fetch PC with next-PC selection, valid/ready
// fetch handshake, boot/halt state machine and optional return-address stack.
// Build option: define PC_RAS_EN to instantiate the RAS (pc_ras); without it
// returns always use ret_target_i and call_i is ignored.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   pc_ready_i, stall_i   : imem accept / pipeline stall (sequential advance only)
//   br_*, jmp_*, ret_*    : redirect requests and targets
//   call_i, call_link_i   : jump is a call; link is pushed onto the RAS
//   trap_i                : exception redirect to TRAP_VECTOR
//   halt_i, resume_i      : enter / leave HALT
//   pc_o, pc_valid_o      : fetch request
//   pc_plus4_o            : pc_o + 4
//   misalign_o            : one-cycle pulse on a misaligned redirect target
//   ras_empty_o/full_o    : RAS occupancy
//
// state | meaning
// BOOT  | first cycle after reset; no fetch, redirects ignored
// RUN   | fetching; next PC selected by priority every cycle
// HALT  | no fetch, pc_o frozen; only resume_i or trap_i leave
module pc_fetch_ctrl
    import pc_pkg::*;
#(
    parameter int              XLEN         = DEF_XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEF_TRAP_VECTOR),
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pc_ready_i,
    input  logic            stall_i,
    input  logic            br_taken_i,
    input  logic [XLEN-1:0] br_target_i,
    input  logic            jmp_i,
    input  logic [XLEN-1:0] jmp_target_i,
    input  logic            call_i,
    input  logic [XLEN-1:0] call_link_i,
    input  logic            ret_i,
    input  logic [XLEN-1:0] ret_target_i,
    input  logic            trap_i,
    input  logic            halt_i,
    input  logic            resume_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            misalign_o,
    output logic            ras_empty_o,
    output logic            ras_full_o
);

    fetch_state_t    state;
    next_sel_t       sel;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] ret_value;
    logic            misaligned;
    logic            in_run;

    assign in_run     = (state == RUN);
    assign pc_plus4_o = pc_o + XLEN'(INSTR_BYTES);

`ifdef PC_RAS_EN
    logic [XLEN-1:0] ras_top;
    logic            ras_push;
    logic            ras_pop;

    // stack traffic only happens in RUN, whatever redirect wins the priority
    assign ras_push = in_run && call_i && jmp_i;
    assign ras_pop  = in_run && ret_i && !ras_empty_o;

    pc_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (call_link_i),
        .top       (ras_top),
        .empty     (ras_empty_o),
        .full      (ras_full_o)
    );

    assign ret_value = ras_empty_o ? ret_target_i : ras_top;
`else
    logic unused_call;

    assign ras_empty_o = 1'b1;
    assign ras_full_o  = 1'b0;
    assign ret_value   = ret_target_i;
    assign unused_call = ^{call_i, call_link_i};
`endif

    always_comb begin
        sel = SEL_HOLD;
        if (trap_i)                        sel = SEL_TRAP;
        else if (ret_i)                    sel = SEL_RET;
        else if (jmp_i)                    sel = SEL_JMP;
        else if (br_taken_i)               sel = SEL_BR;
        else if (pc_ready_i && !stall_i)   sel = SEL_SEQ;
    end

    always_comb begin
        target = pc_o;
        case (sel)
            SEL_TRAP: target = TRAP_VECTOR;
            SEL_RET:  target = ret_value;
            SEL_JMP:  target = jmp_target_i;
            SEL_BR:   target = br_target_i;
            SEL_SEQ:  target = pc_plus4_o;
            default:  target = pc_o;
        endcase
    end

    assign misaligned = (sel inside {SEL_RET, SEL_JMP, SEL_BR}) && (target[1:0] != 2'b00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= BOOT;
            pc_o       <= RESET_VECTOR;
            pc_valid_o <= 1'b0;
            misalign_o <= 1'b0;
        end else begin
            misalign_o <= 1'b0;
            case (state)
                BOOT: begin
                    state      <= RUN;
                    pc_valid_o <= 1'b1;
                end
                RUN: begin
                    pc_o       <= misaligned ? TRAP_VECTOR : target;
                    misalign_o <= misaligned;
                    // any redirect wins over halt; an accepted fetch still advances
                    if (halt_i && (sel inside {SEL_SEQ, SEL_HOLD})) begin
                        state      <= HALT;
                        pc_valid_o <= 1'b0;
                    end
                end
                HALT: begin
                    if (trap_i) begin
                        pc_o       <= TRAP_VECTOR;
                        state      <= RUN;
                        pc_valid_o <= 1'b1;
                    end else if (resume_i) begin
                        state      <= RUN;
                        pc_valid_o <= 1'b1;
                    end
                end
                default: begin
                    state      <= BOOT;
                    pc_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: table-driven and randomized bench for pc_fetch_ctrl,
// checked every cycle against a queue-based reference model.
module tb_pc_fetch_ctrl;

`ifdef PC_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif
    localparam int          DEPTH = 4;
    localparam logic [31:0] TRAPV = 32'h0000_0080;

    localparam int F_RDY  = 1;
    localparam int F_STL  = 2;
    localparam int F_BR   = 4;
    localparam int F_JMP  = 8;
    localparam int F_CALL = 16;
    localparam int F_RET  = 32;
    localparam int F_TRAP = 64;
    localparam int F_HALT = 128;
    localparam int F_RES  = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pc_ready_i = 1'b0, stall_i = 1'b0, br_taken_i = 1'b0, jmp_i = 1'b0;
    logic        call_i = 1'b0, ret_i = 1'b0, trap_i = 1'b0, halt_i = 1'b0, resume_i = 1'b0;
    logic [31:0] br_target_i = '0, jmp_target_i = '0, call_link_i = '0, ret_target_i = '0;
    logic [31:0] pc_o, pc_plus4_o;
    logic        pc_valid_o, misalign_o, ras_empty_o, ras_full_o;

    int n_pass = 0;
    int n_total = 0;

    pc_fetch_ctrl #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0000_0000),
        .TRAP_VECTOR  (TRAPV),
        .RAS_DEPTH    (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pc_ready_i   (pc_ready_i),
        .stall_i      (stall_i),
        .br_taken_i   (br_taken_i),
        .br_target_i  (br_target_i),
        .jmp_i        (jmp_i),
        .jmp_target_i (jmp_target_i),
        .call_i       (call_i),
        .call_link_i  (call_link_i),
        .ret_i        (ret_i),
        .ret_target_i (ret_target_i),
        .trap_i       (trap_i),
        .halt_i       (halt_i),
        .resume_i     (resume_i),
        .pc_o         (pc_o),
        .pc_valid_o   (pc_valid_o),
        .pc_plus4_o   (pc_plus4_o),
        .misalign_o   (misalign_o),
        .ras_empty_o  (ras_empty_o),
        .ras_full_o   (ras_full_o)
    );

    always #5 clk = ~clk;

    // reference model: phase 0 = boot, 1 = running, 2 = halted
    logic [31:0] m_pc;
    int          m_phase;
    bit          m_mis;
    logic [31:0] m_ras[$];

    function automatic void model_reset();
        m_pc    = 32'h0;
        m_phase = 0;
        m_mis   = 1'b0;
        m_ras.delete();
    endfunction

    function automatic void model_step();
        logic [31:0] nxt;
        bit          have;
        bit          redirect;
        m_mis = 1'b0;
        if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 2) begin
            if (trap_i) begin
                m_pc = TRAPV;
                m_phase = 1;
            end else if (resume_i) begin
                m_phase = 1;
            end
        end else begin
            have     = RAS_EN && (m_ras.size() > 0);
            redirect = trap_i || ret_i || jmp_i || br_taken_i;
            if (trap_i)                      nxt = TRAPV;
            else if (ret_i)                  nxt = have ? m_ras[$] : ret_target_i;
            else if (jmp_i)                  nxt = jmp_target_i;
            else if (br_taken_i)             nxt = br_target_i;
            else if (pc_ready_i && !stall_i) nxt = m_pc + 32'd4;
            else                             nxt = m_pc;
            if (!trap_i && redirect && (nxt % 4 != 0)) begin
                nxt   = TRAPV;
                m_mis = 1'b1;
            end
            if (RAS_EN) begin
                if (ret_i && have) void'(m_ras.pop_back());
                if (call_i && jmp_i) begin
                    m_ras.push_back(call_link_i);
                    if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
                end
            end
            if (halt_i && !redirect) m_phase = 2;
            m_pc = nxt;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    endtask

    task automatic check_model();
        chk("pc", pc_o, m_pc);
        chk("pc_valid", {31'b0, pc_valid_o}, {31'b0, m_phase == 1});
        chk("pc_plus4", pc_plus4_o, m_pc + 32'd4);
        chk("misalign", {31'b0, misalign_o}, {31'b0, m_mis});
        chk("ras_empty", {31'b0, ras_empty_o}, {31'b0, m_ras.size() == 0});
        chk("ras_full", {31'b0, ras_full_o}, {31'b0, m_ras.size() == DEPTH});
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic drive(input int flags, input logic [31:0] tgt);
        pc_ready_i   = (flags & F_RDY) != 0;
        stall_i      = (flags & F_STL) != 0;
        br_taken_i   = (flags & F_BR) != 0;
        jmp_i        = (flags & F_JMP) != 0;
        call_i       = (flags & F_CALL) != 0;
        ret_i        = (flags & F_RET) != 0;
        trap_i       = (flags & F_TRAP) != 0;
        halt_i       = (flags & F_HALT) != 0;
        resume_i     = (flags & F_RES) != 0;
        br_target_i  = tgt;
        jmp_target_i = tgt;
        call_link_i  = tgt;
        ret_target_i = tgt;
    endtask

    typedef struct {
        int          flags;
        logic [31:0] tgt;
        logic [31:0] exp_pc;
        bit          exp_valid;
        bit          exp_mis;
    } vec_t;

    function automatic vec_t mk(int flags, logic [31:0] tgt, logic [31:0] pc, bit valid, bit mis);
        vec_t v;
        v.flags = flags; v.tgt = tgt; v.exp_pc = pc; v.exp_valid = valid; v.exp_mis = mis;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        vecs.push_back(mk(F_RDY, 0, 32'h0, 1, 0));
        vecs.push_back(mk(F_RDY, 0, 32'h4, 1, 0));
        vecs.push_back(mk(F_RDY, 0, 32'h8, 1, 0));
        vecs.push_back(mk(F_RDY, 0, 32'hC, 1, 0));
        vecs.push_back(mk(F_RDY, 0, 32'h10, 1, 0));
        vecs.push_back(mk(0, 0, 32'h10, 1, 0));
        vecs.push_back(mk(0, 0, 32'h10, 1, 0));
        vecs.push_back(mk(0, 0, 32'h10, 1, 0));
        vecs.push_back(mk(F_RDY, 0, 32'h14, 1, 0));
        vecs.push_back(mk(F_RDY | F_STL, 0, 32'h14, 1, 0));
        vecs.push_back(mk(F_RDY | F_STL, 0, 32'h14, 1, 0));
        vecs.push_back(mk(F_RDY, 0, 32'h18, 1, 0));
        vecs.push_back(mk(F_TRAP | F_JMP | F_BR | F_STL, 32'h200, 32'h80, 1, 0));
        vecs.push_back(mk(F_RDY | F_JMP, 32'h202, 32'h80, 1, 1));
        vecs.push_back(mk(F_RDY, 0, 32'h84, 1, 0));
        vecs.push_back(mk(F_BR, 32'h1000, 32'h1000, 1, 0));
        vecs.push_back(mk(F_RET, 32'h600, 32'h600, 1, 0));
        vecs.push_back(mk(F_HALT, 0, 32'h600, 0, 0));
        vecs.push_back(mk(F_RDY, 0, 32'h600, 0, 0));
        vecs.push_back(mk(F_JMP, 32'h700, 32'h600, 0, 0));
        vecs.push_back(mk(F_RES, 0, 32'h600, 1, 0));
        vecs.push_back(mk(F_RDY, 0, 32'h604, 1, 0));
        vecs.push_back(mk(F_HALT, 0, 32'h604, 0, 0));
        vecs.push_back(mk(F_TRAP, 0, 32'h80, 1, 0));
        vecs.push_back(mk(F_HALT | F_JMP, 32'h900, 32'h900, 1, 0));
        vecs.push_back(mk(F_RDY, 0, 32'h904, 1, 0));
        vecs.push_back(mk(F_JMP, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0));
        vecs.push_back(mk(F_RDY, 0, 32'h0, 1, 0));

        // reset and boot
        model_reset();
        drive(F_RDY, 0);
        @(negedge clk);
        #1;
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_valid", {31'b0, pc_valid_o}, 32'h0);
        chk("rst_empty", {31'b0, ras_empty_o}, 32'h1);
        chk("rst_full", {31'b0, ras_full_o}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        check_model();

        foreach (vecs[i]) begin
            drive(vecs[i].flags, vecs[i].tgt);
            cycle();
            chk($sformatf("vec%0d_pc", i), pc_o, vecs[i].exp_pc);
            chk($sformatf("vec%0d_valid", i), {31'b0, pc_valid_o}, {31'b0, vecs[i].exp_valid});
            chk($sformatf("vec%0d_mis", i), {31'b0, misalign_o}, {31'b0, vecs[i].exp_mis});
        end

        // five calls then five returns
        for (int k = 1; k <= 5; k++) begin
            drive(F_JMP | F_CALL, 32'h1000);
            call_link_i = 32'h100 * k;
            cycle();
            chk($sformatf("call%0d_full", k), {31'b0, ras_full_o}, {31'b0, RAS_EN && k >= 4});
        end
        for (int k = 0; k < 5; k++) begin
            drive(F_RET, 32'h2000);
            cycle();
            chk($sformatf("ret%0d_pc", k), pc_o,
                (RAS_EN && k < 4) ? 32'h500 - 32'h100 * k : 32'h2000);
            chk($sformatf("ret%0d_empty", k), {31'b0, ras_empty_o}, {31'b0, !RAS_EN || k >= 3});
        end

        // simultaneous push and pop
        drive(F_JMP | F_CALL, 32'h1000);
        call_link_i = 32'h100;
        cycle();
        drive(F_JMP | F_CALL | F_RET, 32'h1000);
        call_link_i  = 32'h300;
        ret_target_i = 32'h2000;
        cycle();
        chk("pushpop_pc", pc_o, RAS_EN ? 32'h100 : 32'h2000);
        drive(F_RET, 32'h2000);
        cycle();
        chk("pushpop_ret", pc_o, RAS_EN ? 32'h300 : 32'h2000);
        chk("pushpop_empty", {31'b0, ras_empty_o}, 32'h1);

        // reset mid-run with two RAS entries
        drive(F_JMP | F_CALL, 32'h30);
        call_link_i = 32'h500;
        cycle();
        drive(F_JMP | F_CALL, 32'h40);
        call_link_i = 32'h600;
        cycle();
        chk("mid_pc", pc_o, 32'h40);
        drive(F_RDY, 0);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("mid_rst_pc", pc_o, 32'h0);
        chk("mid_rst_valid", {31'b0, pc_valid_o}, 32'h0);
        chk("mid_rst_empty", {31'b0, ras_empty_o}, 32'h1);
        @(negedge clk);
        reset = 1'b0;
        drive(F_RET, 32'h700);
        cycle();
        chk("boot_ignores_ret", pc_o, 32'h0);
        drive(F_RET, 32'h700);
        cycle();
        chk("post_rst_ret", pc_o, 32'h700);

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [31:0] t, l;
            t = $urandom();
            l = $urandom();
            if ($urandom_range(0, 9) != 0) t[1:0] = 2'b00;
            if ($urandom_range(0, 9) != 0) l[1:0] = 2'b00;
            pc_ready_i   = $urandom_range(0, 3) != 0;
            stall_i      = $urandom_range(0, 4) == 0;
            trap_i       = $urandom_range(0, 29) == 0;
            ret_i        = $urandom_range(0, 7) == 0;
            jmp_i        = $urandom_range(0, 5) == 0;
            call_i       = $urandom_range(0, 1) == 0;
            br_taken_i   = $urandom_range(0, 7) == 0;
            halt_i       = $urandom_range(0, 19) == 0;
            resume_i     = $urandom_range(0, 3) == 0;
            br_target_i  = t;
            jmp_target_i = {t[31:4], 4'h0} | {30'b0, t[1:0]};
            call_link_i  = l;
            ret_target_i = t ^ 32'h0000_1000;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
